// File: rtl/seq_div_if.sv
// Operand/result handshake bundle for the sequential divider.
// The command source / result consumer uses the master modport; the divider uses slave.
interface seq_div_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// One operation in flight; operands and results move over valid/ready handshakes.
// Divide-by-zero returns all-ones quotient, remainder = dividend, and raises div_by_zero.
module seq_div #(
    parameter int WIDTH = 8
) (
    input  logic     clk,
    input  logic     rst,
    seq_div_if.slave bus
);
    localparam int            CW  = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] ONE = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Iteration bookkeeping
    logic [CW-1:0]    count_reg, count_next;
    // Partial remainder carries one extra bit so the trial subtraction borrow is visible
    logic [WIDTH:0]   prem_reg, prem_next;
    // Shift register: starts holding the dividend, fills with quotient bits from the LSB
    logic [WIDTH-1:0] qsh_reg, qsh_next;
    logic [WIDTH-1:0] divisor_reg, divisor_next;

    // Result registers presented to the consumer
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dbz_reg, dbz_next;

    // Single restoring step
    logic [2*WIDTH:0] pair_shift;
    logic [WIDTH:0]   shifted_rem;
    logic [WIDTH:0]   trial;
    logic             trial_ok;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_q;

    // One restoring iteration: shift {rem, q} left, trial-subtract, keep on no borrow
    always_comb begin
        pair_shift  = {prem_reg, qsh_reg} << 1;
        shifted_rem = pair_shift[2*WIDTH:WIDTH];
        trial       = shifted_rem - {1'b0, divisor_reg};
        trial_ok    = ~trial[WIDTH];
        step_rem    = trial_ok ? trial : shifted_rem;
        step_q      = pair_shift[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, trial_ok};
    end

    // Next-state and datapath-next logic for the IDLE/RUN/DONE controller
    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        prem_next      = prem_reg;
        qsh_next       = qsh_reg;
        divisor_next   = divisor_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dbz_next       = dbz_reg;

        unique case (state_reg)
            IDLE: begin
                // in_ready is high throughout IDLE, so in_valid alone means accept
                if (bus.in_valid) begin
                    prem_next    = '0;
                    qsh_next     = bus.dividend;
                    divisor_next = bus.divisor;
                    if (bus.divisor != '0) begin
                        count_next = CNT_LOAD;
                        state_next = RUN;
                    end else begin
                        // Zero divisor skips iteration and publishes the fixed result
                        quotient_next  = '1;
                        remainder_next = bus.dividend;
                        dbz_next       = 1'b1;
                        state_next     = DONE;
                    end
                end
            end
            RUN: begin
                prem_next  = step_rem;
                qsh_next   = step_q;
                count_next = count_reg - ONE;
                if (count_reg == ONE) begin
                    // Last bit: publish the result on the same edge we enter DONE
                    quotient_next  = step_q;
                    remainder_next = step_rem[WIDTH-1:0];
                    dbz_next       = 1'b0;
                    state_next     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            prem_reg      <= '0;
            qsh_reg       <= '0;
            divisor_reg   <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            prem_reg      <= prem_next;
            qsh_reg       <= qsh_next;
            divisor_reg   <= divisor_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dbz_reg       <= dbz_next;
        end
    end

    // Handshake flags decode the state register only, never the peer's signals
    assign bus.in_ready    = (state_reg == IDLE);
    assign bus.out_valid   = (state_reg == DONE);
    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_seq_div.sv
// Testbench for seq_div: directed literal cases plus a random stream checked
// every cycle against a transaction-level model (plain / and %).
module tb_seq_div;
    localparam int W = 8;

    logic clk;
    logic rst;

    seq_div_if #(.WIDTH(W)) bus ();

    seq_div #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + per-cycle compare ----------------
    bit         model_ok = 0;
    bit         busy     = 0;
    longint     k        = 0;
    longint     due      = 0;
    int         pq, pr, pz;
    int         shown_q  = 0;
    int         shown_r  = 0;
    int         shown_z  = 0;
    int         n_acc    = 0;
    int         n_res    = 0;
    int         n_abort  = 0;

    always @(negedge clk) begin
        k++;
        if (model_ok) begin
            if (busy && k == due) begin
                shown_q = pq;
                shown_r = pr;
                shown_z = pz;
            end
            chk("m_in_ready", bus.in_ready, int'(!busy));
            chk("m_out_valid", bus.out_valid, int'(busy && k >= due));
            chk("m_quotient", bus.quotient, shown_q);
            chk("m_remainder", bus.remainder, shown_r);
            chk("m_div_by_zero", bus.div_by_zero, shown_z);
            if (bus.out_valid && bus.out_ready) n_res++;
        end
        if (rst) begin
            if (busy) n_abort++;
            busy     = 0;
            shown_q  = 0;
            shown_r  = 0;
            shown_z  = 0;
            model_ok = 1;
        end else if (model_ok) begin
            if (!busy && bus.in_valid) begin
                busy = 1;
                n_acc++;
                if (bus.divisor == 0) begin
                    due = k + 1;
                    pq  = (1 << W) - 1;
                    pr  = int'(bus.dividend);
                    pz  = 1;
                end else begin
                    due = k + W + 1;
                    pq  = int'(bus.dividend) / int'(bus.divisor);
                    pr  = int'(bus.dividend) % int'(bus.divisor);
                    pz  = 0;
                end
            end else if (busy && k >= due && bus.out_ready) begin
                busy = 0;
            end
        end
    end

    // ---------------- directed operation with literal expectations ----------------
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                      input int eq, input int er, input int ez);
        int n;
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.out_ready = (hold == 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        chk("accept_timeout", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.dividend = W'($urandom);
        bus.divisor  = W'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!bus.out_valid) chk("busy_in_ready", bus.in_ready, 0);
        end while (!bus.out_valid && lat < 100);
        chk("latency", lat, (b == 0) ? 1 : W + 1);
        chk("lit_quotient", bus.quotient, eq);
        chk("lit_remainder", bus.remainder, er);
        chk("lit_div_by_zero", bus.div_by_zero, ez);
        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                chk("hold_out_valid", bus.out_valid, 1);
                chk("hold_in_ready", bus.in_ready, 0);
                chk("hold_quotient", bus.quotient, eq);
                chk("hold_remainder", bus.remainder, er);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
            @(negedge clk);
        end
        @(negedge clk);
        chk("post_in_ready", bus.in_ready, 1);
        chk("post_out_valid", bus.out_valid, 0);
    endtask

    initial begin
        int  sent;
        int  guard;
        bit  pres;
        bit  acc;
        int  sel;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_quotient", bus.quotient, 0);
        chk("rst_remainder", bus.remainder, 0);

        op(8'd100, 8'd7,   0, 14,  2,  0);
        op(8'd5,   8'd9,   0, 0,   5,  0);
        op(8'd255, 8'd1,   0, 255, 0,  0);
        op(8'd255, 8'd255, 0, 1,   0,  0);
        op(8'd42,  8'd0,   0, 255, 42, 1);
        op(8'd200, 8'd13,  5, 15,  5,  0);

        // Reset during the 4th RUN cycle of 100/7
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 8'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", bus.in_ready, 1);
        chk("abort_out_valid", bus.out_valid, 0);
        chk("abort_quotient", bus.quotient, 0);
        chk("abort_remainder", bus.remainder, 0);
        op(8'd9, 8'd3, 0, 3, 0, 0);

        // Random stream with gaps on both handshakes
        sent  = 0;
        guard = 0;
        pres  = 0;
        acc   = 0;
        while (sent < 500 && guard < 60000) begin
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                pres = 0;
                sent++;
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!pres && sent < 500 && $urandom_range(0, 2) != 0) begin
                pres = 1;
                sel  = $urandom_range(0, 7);
                bus.dividend = (sel == 7) ? 8'hFF : W'($urandom);
                case (sel)
                    0:       bus.divisor = 8'd0;
                    1:       bus.divisor = 8'd1;
                    2:       bus.divisor = 8'hFF;
                    default: bus.divisor = W'($urandom);
                endcase
            end
            bus.in_valid = pres;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
        end
        chk("stream_complete", sent, 500);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_timeout", int'(busy), 0);
        @(negedge clk);
        chk("results_vs_accepts", n_res, n_acc - n_abort);
        chk("random_accepts", n_acc, 500 + 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
